// File: rtl/read_control_block.sv
// Read-side FIFO control: qualifies reads against the empty flag, owns the
// binary read pointer, and supplies a registered Gray copy, a data-valid strobe and a sticky underflow flag.
module read_control_block #(
  parameter int A_LENGTH = 4
) (
  input  logic                rd_clk,
  input  logic                reset,
  input  logic                enable_rd,
  input  logic                f_empty,
  input  logic                clr_underflow,
  output logic                enable_rd_out,
  output logic [A_LENGTH:0]   rd_ptr,
  output logic                MSB_rd_ptr,
  output logic [A_LENGTH-1:0] b_rd_ptr,
  output logic [A_LENGTH:0]   rd_ptr_gray,
  output logic                rd_valid,
  output logic                underflow
);

  localparam logic [A_LENGTH:0] PtrOne = {{A_LENGTH{1'b0}}, 1'b1};

  logic [A_LENGTH:0] ptr_q, ptr_d;
  logic [A_LENGTH:0] gray_q, gray_d;
  logic              valid_q;
  logic              underflow_q, underflow_d;

  assign enable_rd_out = enable_rd & ~f_empty;

  // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ptr_d       = ptr_q;
    underflow_d = underflow_q;
    if (enable_rd_out) begin
      ptr_d = ptr_q + PtrOne;
    end
    // Gray is derived from the next pointer so both registers move on the same edge.
    gray_d = ptr_d ^ (ptr_d >> 1);
    // Set has priority over clear so a simultaneous underflow is never lost.
    if (enable_rd && f_empty) begin
      underflow_d = 1'b1;
    end else if (clr_underflow) begin
      underflow_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      gray_q      <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      gray_q      <= gray_d;
      valid_q     <= enable_rd_out;
      underflow_q <= underflow_d;
    end
  end

  assign rd_ptr      = ptr_q;
  assign MSB_rd_ptr  = ptr_q[A_LENGTH];
  assign b_rd_ptr    = ptr_q[A_LENGTH-1:0];
  assign rd_ptr_gray = gray_q;
  assign rd_valid    = valid_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_read_control_block.sv
// Randomised self-checking bench for read_control_block against a
// read-count model of the pointer, Gray code, valid strobe and underflow flag.
module tb_read_control_block;

  localparam int AW  = 4;
  localparam int MOD = 1 << (AW + 1);

  logic          rd_clk = 1'b0;
  logic          reset;
  logic          enable_rd, f_empty, clr_underflow;
  logic          enable_rd_out;
  logic [AW:0]   rd_ptr, rd_ptr_gray;
  logic          MSB_rd_ptr;
  logic [AW-1:0] b_rd_ptr;
  logic          rd_valid, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: total accepted reads modulo pointer range.
  int exp_ptr   = 0;
  int exp_valid = 0;
  int exp_uf    = 0;

  read_control_block #(.A_LENGTH(AW)) dut (
    .rd_clk        (rd_clk),
    .reset         (reset),
    .enable_rd     (enable_rd),
    .f_empty       (f_empty),
    .clr_underflow (clr_underflow),
    .enable_rd_out (enable_rd_out),
    .rd_ptr        (rd_ptr),
    .MSB_rd_ptr    (MSB_rd_ptr),
    .b_rd_ptr      (b_rd_ptr),
    .rd_ptr_gray   (rd_ptr_gray),
    .rd_valid      (rd_valid),
    .underflow     (underflow)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_gray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".ptr"},   32'(rd_ptr),      32'(exp_ptr));
    check({tag, ".msb"},   32'(MSB_rd_ptr),  32'(exp_ptr / (MOD / 2)));
    check({tag, ".baddr"}, 32'(b_rd_ptr),    32'(exp_ptr % (MOD / 2)));
    check({tag, ".gray"},  32'(rd_ptr_gray), 32'(to_gray(exp_ptr)));
    check({tag, ".valid"}, 32'(rd_valid),    32'(exp_valid));
    check({tag, ".uf"},    32'(underflow),   32'(exp_uf));
  endtask

  // Drives one cycle's inputs just after an edge, then checks after the next edge.
  task automatic cycle(input logic en, input logic fe, input logic clr, input string tag);
    int accepted;
    enable_rd     = en;
    f_empty       = fe;
    clr_underflow = clr;
    #1;
    accepted = (en && !fe) ? 1 : 0;
    check({tag, ".rdout"}, 32'(enable_rd_out), 32'(accepted));
    if (accepted == 1) exp_ptr = (exp_ptr + 1) % MOD;
    exp_valid = accepted;
    if (en && fe)  exp_uf = 1;
    else if (clr)  exp_uf = 0;
    @(posedge rd_clk);
    #1;
    check_state(tag);
  endtask

  initial begin
    reset         = 1'b1;
    enable_rd     = 1'b0;
    f_empty       = 1'b1;
    clr_underflow = 1'b0;
    #1;
    check_state("reset");
    #2 reset = 1'b0;
    @(posedge rd_clk);
    #1;
    check_state("post_reset");

    // Three streaming reads: pointer 1,2,3 with continuous valid.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, "stream3");
    check("gray_at_3", 32'(rd_ptr_gray), 32'h2);

    // Advance to 30, then across the wrap: 31, 0, 1.
    for (int i = 0; i < 27; i++) cycle(1'b1, 1'b0, 1'b0, "preload");
    check("ptr_at_30", 32'(rd_ptr), 32'd30);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, "wrap");

    // Underflow: blocked reads, sticky until cleared.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, "empty_rd");
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, "uf_hold");
    cycle(1'b0, 1'b1, 1'b1, "uf_clr");
    cycle(1'b0, 1'b0, 1'b0, "idle");
    // Set and clear together: set must win.
    cycle(1'b1, 1'b1, 1'b1, "set_wins");
    // Empty deasserting: read accepted in that same cycle.
    cycle(1'b1, 1'b0, 1'b0, "empty_drop");

    // Stream to pointer 9, then reset asynchronously mid-cycle.
    while (exp_ptr != 9) cycle(1'b1, 1'b0, 1'b0, "to9");
    enable_rd = 1'b1;
    f_empty   = 1'b0;
    #2 reset  = 1'b1;
    exp_ptr   = 0;
    exp_valid = 0;
    exp_uf    = 0;
    #1;
    check_state("async_rst");
    // Read requested on an edge while reset is held: nothing moves.
    @(posedge rd_clk);
    #1;
    check_state("rst_hold");
    #2 reset = 1'b0;
    enable_rd = 1'b0;
    @(posedge rd_clk);
    #1;
    check_state("rst_release");

    // Randomised traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 8) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_control_block.md
Name: read_control_block

Overview:
- Read-side control for the FIFO; the counterpart of the write control block.
- Owns the read pointer, a binary up counter A_LENGTH+1 bits wide. The extra MSB is the wrap bit used by the full/empty flag logic.
- Gates read requests with the empty flag and supplies the RAM read address.
- Produces a registered Gray-coded copy of the pointer for cross-domain synchronisation, a read-data-valid strobe aligned to the synchronous RAM latency, and a sticky underflow flag.

Parameters:
- A_LENGTH, 4, RAM address width; FIFO depth = 2**A_LENGTH.

Ports:
- rd_clk  input  1  read-domain clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable_rd  input  1  read request from consumer.
- f_empty  input  1  empty flag from flag logic, already in the rd_clk domain.
- clr_underflow  input  1  synchronous clear of the underflow flag.
- enable_rd_out  output  1  qualified read: RAM read enable and counter increment.
- rd_ptr  output  A_LENGTH+1  binary read pointer.
- MSB_rd_ptr  output  1  rd_ptr[A_LENGTH], wrap bit for the flag logic.
- b_rd_ptr  output  A_LENGTH  rd_ptr[A_LENGTH-1:0], RAM read address.
- rd_ptr_gray  output  A_LENGTH+1  registered Gray code of rd_ptr.
- rd_valid  output  1  RAM read data valid.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: asserting reset clears rd_ptr, rd_ptr_gray, rd_valid and underflow to 0 immediately, independent of rd_clk. This holds mid-operation, including a reset arriving in the same cycle as a read.
- After reset deasserts, the first increment occurs at the first rd_clk edge where enable_rd_out=1.
- enable_rd_out = enable_rd & ~f_empty. This is combinational, with no added latency.
- Counter:
  - on a rising edge with enable_rd_out=1: rd_ptr <= rd_ptr + 1, modulo 2**(A_LENGTH+1);
  - otherwise rd_ptr holds.
  - Wrap: for A_LENGTH=4, 5'b11111 -> 5'b00000, and MSB_rd_ptr toggles on every 2**A_LENGTH reads.
- MSB_rd_ptr and b_rd_ptr are pure bit-slices of rd_ptr: {MSB_rd_ptr, b_rd_ptr} == rd_ptr at all times.
- Gray pointer:
  - rd_ptr_gray is registered on the same edge as rd_ptr, computed from the next pointer value as nxt ^ (nxt >> 1).
  - Invariant at all times after any edge or reset: rd_ptr_gray == rd_ptr ^ (rd_ptr >> 1).
  - Exactly one bit of rd_ptr_gray changes per increment, including across the wrap; no glitch cycles.
- rd_valid:
  - rd_valid <= enable_rd_out on each edge, i.e. high exactly one cycle after each accepted read.
  - Back-to-back accepted reads give a continuous rd_valid.
- Underflow:
  - set on an edge where enable_rd=1 and f_empty=1; the pointer does not move;
  - cleared on an edge where clr_underflow=1;
  - if set and clear occur on the same edge, set wins and underflow stays 1;
  - otherwise it holds.
- Empty boundary:
  - f_empty=1 blocks increments regardless of enable_rd.
  - If f_empty deasserts, a read is accepted in the same cycle that enable_rd is high.
- The block never inspects the write pointer; full/empty comparison stays in the flag logic.

Test Plan (A_LENGTH=4):
- Reset, then f_empty=0 and enable_rd=1 for 3 cycles -> rd_ptr 0->1->2->3; b_rd_ptr=3; rd_valid high for 3 cycles starting 1 cycle after the first read; rd_ptr_gray=5'b00010.
- Preload rd_ptr to 30 via 30 accepted reads, then 3 more -> rd_ptr 31, 0, 1. MSB_rd_ptr goes 1->0 at the wrap. rd_ptr_gray goes 5'b10000 -> 5'b00000, a single-bit change.
- f_empty=1 and enable_rd=1 for 2 cycles -> enable_rd_out=0; rd_ptr holds; rd_valid=0; underflow=1. underflow stays 1 after enable_rd drops, until clr_underflow pulses, then becomes 0.
- enable_rd=1, f_empty=1 and clr_underflow=1 on the same edge -> underflow=1 (set wins).
- Assert reset asynchronously between clock edges while rd_ptr=9 and reads are streaming -> rd_ptr, rd_ptr_gray, rd_valid and underflow read 0 before the next rd_clk edge.
- Random enable_rd/f_empty for 10k cycles -> every cycle: rd_ptr_gray == rd_ptr ^ (rd_ptr>>1); rd_ptr increments by exactly 1 iff enable_rd_out was 1 on the previous edge; rd_valid == previous enable_rd_out.
